// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCpuLo,
    StCpuLoRec,
    StCpuHi,
    StCpuHiRec,
    StVid,
    StAck
  } state_e;

  // Grant encoding, also used for the last-grant fairness register.
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_VID = 1'b1;

  // Halfword select appended as the SRAM address LSB.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Phase timer width; never below one bit so WAIT=0 still builds.
  function automatic int unsigned timer_width(input int unsigned wait_cycles);
    int unsigned w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter that times the strobe phase of an SRAM half-access.
module sram_phase_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             last
);

  logic [WIDTH-1:0] count_q;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign last = (count_q == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the single 16-bit async SRAM between a 32-bit CPU port and a
// read-only 16-bit video fetch port. All pad-facing outputs are registered
// from the next-state decode so the strobes are glitch-free.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ASIZE     = 20,
  parameter int unsigned RAM_ASIZE = 18,
  parameter int unsigned WAIT      = 1
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 cpu_req,
  input  logic                 cpu_rnw,
  input  logic [ASIZE-1:0]     cpu_addr,
  input  logic [31:0]          cpu_dout,
  output logic [31:0]          cpu_din,
  output logic                 cpu_ack,
  input  logic                 vid_req,
  input  logic [RAM_ASIZE-1:0] vid_addr,
  output logic [15:0]          vid_din,
  output logic                 vid_ack,
  output logic                 ram_cs_b,
  output logic                 ram_oe_b,
  output logic                 ram_we_b,
  output logic [RAM_ASIZE-1:0] ram_addr,
  output logic [15:0]          ram_data_out,
  input  logic [15:0]          ram_data_in,
  output logic                 ram_data_oe
);

  localparam int unsigned TW = timer_width(WAIT);

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   rnw_q, rnw_d;
  logic   timer_load, timer_last;

  logic                 cs_b_d, oe_b_d, we_b_d, data_oe_d;
  logic                 cpu_ack_d, vid_ack_d;
  logic [RAM_ASIZE-1:0] addr_d;
  logic [15:0]          dout_d;
  logic [31:0]          cpu_din_q;
  logic [15:0]          vid_din_q;

  // CPU address bits above the SRAM range alias and are deliberately ignored.
  logic unused_cpu_addr;
  assign unused_cpu_addr = ^cpu_addr[ASIZE-1:RAM_ASIZE-1];

  // Reload the timer whenever a strobe phase is entered.
  assign timer_load = (state_d != state_q) &&
                      (state_d == StCpuLo || state_d == StCpuHi || state_d == StVid);

  sram_phase_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk      (clk),
    .reset_b  (reset_b),
    .load     (timer_load),
    .load_val (TW'(WAIT)),
    .last     (timer_last)
  );

  // Next-state logic: round-robin grant in IDLE, phase sequencing elsewhere.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rnw_d        = rnw_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req && (!vid_req || last_grant_q == GNT_VID)) begin
          state_d      = StCpuLo;
          last_grant_d = GNT_CPU;
          rnw_d        = cpu_rnw;
        end else if (vid_req) begin
          state_d      = StVid;
          last_grant_d = GNT_VID;
        end
      end
      StCpuLo:    if (timer_last) state_d = rnw_q ? StCpuHi : StCpuLoRec;
      StCpuLoRec: state_d = StCpuHi;
      StCpuHi:    if (timer_last) state_d = rnw_q ? StAck : StCpuHiRec;
      StCpuHiRec: state_d = StAck;
      StVid:      if (timer_last) state_d = StAck;
      StAck:      state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Pad and ack decode for the upcoming cycle; address/data hold by default.
  always_comb begin
    cs_b_d    = 1'b1;
    oe_b_d    = 1'b1;
    we_b_d    = 1'b1;
    data_oe_d = 1'b0;
    cpu_ack_d = 1'b0;
    vid_ack_d = 1'b0;
    addr_d    = ram_addr;
    dout_d    = ram_data_out;
    case (state_d)
      StCpuLo, StCpuHi: begin
        cs_b_d = 1'b0;
        addr_d = {cpu_addr[RAM_ASIZE-2:0], (state_d == StCpuHi) ? HALF_HI : HALF_LO};
        if (rnw_d) begin
          oe_b_d = 1'b0;
        end else begin
          we_b_d    = 1'b0;
          data_oe_d = 1'b1;
          dout_d    = (state_d == StCpuHi) ? cpu_dout[31:16] : cpu_dout[15:0];
        end
      end
      // Recovery: WE released while address and data stay driven.
      StCpuLoRec, StCpuHiRec: begin
        cs_b_d    = 1'b0;
        data_oe_d = 1'b1;
      end
      StVid: begin
        cs_b_d = 1'b0;
        oe_b_d = 1'b0;
        addr_d = vid_addr;
      end
      StAck: begin
        cpu_ack_d = (last_grant_d == GNT_CPU);
        vid_ack_d = (last_grant_d == GNT_VID);
      end
      default: ;
    endcase
  end

  // State, grant history and registered pad outputs.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= StIdle;
      last_grant_q <= GNT_VID;
      rnw_q        <= 1'b1;
      ram_cs_b     <= 1'b1;
      ram_oe_b     <= 1'b1;
      ram_we_b     <= 1'b1;
      ram_data_oe  <= 1'b0;
      ram_addr     <= '0;
      ram_data_out <= '0;
      cpu_ack      <= 1'b0;
      vid_ack      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rnw_q        <= rnw_d;
      ram_cs_b     <= cs_b_d;
      ram_oe_b     <= oe_b_d;
      ram_we_b     <= we_b_d;
      ram_data_oe  <= data_oe_d;
      ram_addr     <= addr_d;
      ram_data_out <= dout_d;
      cpu_ack      <= cpu_ack_d;
      vid_ack      <= vid_ack_d;
    end
  end

  // Read capture on the final strobe cycle of each read phase.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cpu_din_q <= '0;
      vid_din_q <= '0;
    end else if (timer_last) begin
      if (state_q == StCpuLo && rnw_q) cpu_din_q[15:0]  <= ram_data_in;
      if (state_q == StCpuHi && rnw_q) cpu_din_q[31:16] <= ram_data_in;
      if (state_q == StVid)            vid_din_q        <= ram_data_in;
    end
  end

  assign cpu_din = cpu_din_q;
  assign vid_din = vid_din_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM model (WAIT=1).
module tb_sram_arbiter;

  logic        clk;
  logic        reset_b;
  logic        cpu_req, cpu_rnw;
  logic [19:0] cpu_addr;
  logic [31:0] cpu_dout, cpu_din;
  logic        cpu_ack;
  logic        vid_req;
  logic [17:0] vid_addr;
  logic [15:0] vid_din;
  logic        vid_ack;
  logic        ram_cs_b, ram_oe_b, ram_we_b;
  logic [17:0] ram_addr;
  logic [15:0] ram_data_out, ram_data_in;
  logic        ram_data_oe;

  int n_checks = 0;
  int n_fail   = 0;
  int bus_clash = 0;
  int ack_overlap = 0;

  logic [15:0] mem [0:(1<<18)-1];

  sram_arbiter #(
    .ASIZE     (20),
    .RAM_ASIZE (18),
    .WAIT      (1)
  ) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .cpu_req      (cpu_req),
    .cpu_rnw      (cpu_rnw),
    .cpu_addr     (cpu_addr),
    .cpu_dout     (cpu_dout),
    .cpu_din      (cpu_din),
    .cpu_ack      (cpu_ack),
    .vid_req      (vid_req),
    .vid_addr     (vid_addr),
    .vid_din      (vid_din),
    .vid_ack      (vid_ack),
    .ram_cs_b     (ram_cs_b),
    .ram_oe_b     (ram_oe_b),
    .ram_we_b     (ram_we_b),
    .ram_addr     (ram_addr),
    .ram_data_out (ram_data_out),
    .ram_data_in  (ram_data_in),
    .ram_data_oe  (ram_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_data_in = mem[ram_addr];

  // SRAM model: preload, then write whenever CS and WE are both low at an edge.
  initial begin
    for (int i = 0; i < (1 << 18); i++) mem[i] = 16'h0000;
    mem[18'h00024] = 16'hBEEF;
    mem[18'h00025] = 16'hDEAD;
    mem[18'h2AAAA] = 16'h55AA;
    forever begin
      @(posedge clk);
      if (!ram_cs_b && !ram_we_b) mem[ram_addr] = ram_data_out;
    end
  end

  // Continuous bus-turnaround and ack-exclusivity monitor.
  always @(negedge clk) begin
    if (ram_data_oe && !ram_oe_b) bus_clash++;
    if (cpu_ack && vid_ack) ack_overlap++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pins();
    return {28'd0, ram_cs_b, ram_oe_b, ram_we_b, ram_data_oe};
  endfunction

  // CPU read of addr; halves expected at a_lo and a_lo+1, ack on cycle 5.
  task automatic cpu_read(input logic [19:0] addr, input logic [17:0] a_lo,
                          input logic [31:0] exp_data);
    cpu_addr = addr;
    cpu_rnw  = 1'b1;
    cpu_req  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        check_eq($sformatf("rd_addr_%0d", k), 32'(ram_addr), 32'(k <= 2 ? a_lo : a_lo + 18'd1));
        check_eq($sformatf("rd_pins_%0d", k), pins(), 32'h2);
        check_eq($sformatf("rd_noack_%0d", k), 32'(cpu_ack), 32'h0);
      end else begin
        check_eq("rd_ack", 32'(cpu_ack), 32'h1);
        check_eq("rd_data", cpu_din, exp_data);
        check_eq("rd_ack_pins", pins(), 32'hE);
      end
    end
    cpu_req = 1'b0;
    @(negedge clk);
    check_eq("rd_ack_single", 32'(cpu_ack), 32'h0);
  endtask

  initial begin
    int idle_bad;
    logic [31:0] wr_pins [1:7];
    logic [17:0] wr_addr [1:6];
    logic [15:0] wr_data [1:6];
    bit order_q [$];
    logic [31:0] cpu_din_before;

    reset_b  = 1'b0;
    cpu_req  = 1'b0;
    cpu_rnw  = 1'b1;
    cpu_addr = '0;
    cpu_dout = '0;
    vid_req  = 1'b0;
    vid_addr = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    check_eq("rst_pins", pins(), 32'hE);
    check_eq("rst_addr", 32'(ram_addr), 32'h0);
    check_eq("rst_dout", 32'(ram_data_out), 32'h0);
    check_eq("rst_acks", {30'd0, cpu_ack, vid_ack}, 32'h0);
    check_eq("rst_cpu_din", cpu_din, 32'h0);
    check_eq("rst_vid_din", 32'(vid_din), 32'h0);

    // Released with no requests: bus stays quiet.
    reset_b  = 1'b1;
    idle_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pins() != 32'hE || cpu_ack || vid_ack) idle_bad++;
    end
    check_eq("idle_quiet", 32'(idle_bad), 32'h0);

    // CPU read, word 0x12 -> halfwords 0x24/0x25.
    cpu_read(20'h00012, 18'h00024, 32'hDEADBEEF);

    // CPU write 0x12345678 to word 0x3, ack on cycle 7.
    wr_pins = '{32'h5, 32'h5, 32'h7, 32'h5, 32'h5, 32'h7, 32'hE};
    wr_addr = '{18'h6, 18'h6, 18'h6, 18'h7, 18'h7, 18'h7};
    wr_data = '{16'h5678, 16'h5678, 16'h5678, 16'h1234, 16'h1234, 16'h1234};
    cpu_addr = 20'h00003;
    cpu_dout = 32'h12345678;
    cpu_rnw  = 1'b0;
    cpu_req  = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check_eq($sformatf("wr_pins_%0d", k), pins(), wr_pins[k]);
      check_eq($sformatf("wr_ack_%0d", k), 32'(cpu_ack), (k == 7) ? 32'h1 : 32'h0);
      if (k <= 6) begin
        check_eq($sformatf("wr_addr_%0d", k), 32'(ram_addr), 32'(wr_addr[k]));
        check_eq($sformatf("wr_data_%0d", k), 32'(ram_data_out), 32'(wr_data[k]));
      end
    end
    cpu_req = 1'b0;
    check_eq("wr_mem_lo", 32'(mem[18'h6]), 32'h5678);
    check_eq("wr_mem_hi", 32'(mem[18'h7]), 32'h1234);
    @(negedge clk);

    // Video read, ack on cycle 3. Request dropped after cycle 1 must still complete.
    vid_addr = 18'h2AAAA;
    vid_req  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vid_req = 1'b0;
      if (k <= 2) begin
        check_eq($sformatf("vid_addr_%0d", k), 32'(ram_addr), 32'h2AAAA);
        check_eq($sformatf("vid_pins_%0d", k), pins(), 32'h2);
        check_eq($sformatf("vid_noack_%0d", k), 32'(vid_ack), 32'h0);
      end else begin
        check_eq("vid_ack", 32'(vid_ack), 32'h1);
        check_eq("vid_data", 32'(vid_din), 32'h55AA);
        check_eq("vid_cpu_quiet", 32'(cpu_ack), 32'h0);
      end
    end
    @(negedge clk);

    // Contention from reset: CPU wins the first tie, then strict alternation.
    reset_b  = 1'b0;
    cpu_addr = 20'h00012;
    cpu_rnw  = 1'b1;
    cpu_req  = 1'b1;
    vid_req  = 1'b1;
    @(negedge clk);
    reset_b = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cpu_ack) order_q.push_back(1'b0);
      if (vid_ack) order_q.push_back(1'b1);
    end
    cpu_req = 1'b0;
    vid_req = 1'b0;
    check_eq("arb_count_ge4", 32'(order_q.size() >= 4), 32'h1);
    if (order_q.size() >= 4) begin
      check_eq("arb_order", {28'd0, order_q[0], order_q[1], order_q[2], order_q[3]}, 32'h5);
    end
    repeat (10) @(negedge clk);

    // Reset during CPU_HI of a write: strobes release asynchronously, no ack.
    cpu_din_before = cpu_din;
    cpu_addr = 20'h00040;
    cpu_dout = 32'hCAFEF00D;
    cpu_rnw  = 1'b0;
    cpu_req  = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("abort_hi_active", pins(), 32'h5);
    check_eq("abort_hi_addr", 32'(ram_addr), 32'h81);
    #2 reset_b = 1'b0;
    #1 check_eq("abort_async_pins", pins(), 32'hE);
    cpu_req = 1'b0;
    @(negedge clk);
    check_eq("abort_no_ack", 32'(cpu_ack), 32'h0);
    check_eq("abort_hi_not_written", 32'(mem[18'h81]), 32'h0);
    check_eq("abort_lo_written", 32'(mem[18'h80]), 32'hF00D);
    reset_b = 1'b1;
    idle_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cpu_ack || pins() != 32'hE) idle_bad++;
    end
    check_eq("abort_idle_after", 32'(idle_bad), 32'h0);
    check_eq("abort_din_reset", cpu_din, 32'h0);
    if (cpu_din_before == 32'h0) n_fail++;  // contention phase must have loaded cpu_din
    cpu_read(20'h00012, 18'h00024, 32'hDEADBEEF);

    check_eq("bus_turnaround", 32'(bus_clash), 32'h0);
    check_eq("ack_exclusive", 32'(ack_overlap), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
